bit_serial_alu: RTL and testbench
=================================

// Module: bit_serial_alu
// PURPOSE
//   Multi-cycle ALU that drives a single 1-bit ALU slice across WIDTH cycles, LSB first.
//   Holds the operands, feeds invert controls, operation select, carry and less to the slice each cycle.
//   Collects the result bits and the carry chain.
//   Serves as a small-area alternative to the 32-slice ripple ALU in the lab CPU datapath.
//   It talks to the CPU stall logic through a start/busy/done handshake.
// PARAMETERS
//   WIDTH   32   operand/result width in bits; legal range 4..64
// PORTS
//   clk          in   1      rising-edge clock
//   rst          in   1      synchronous, active-high reset
//   start        in   1      request; sampled only in IDLE
//   ALU_control  in   4      0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 1100 NOR, 0111 SLT
//   src1         in   WIDTH  operand A; latched on accepted start
//   src2         in   WIDTH  operand B; latched on accepted start
//   busy         out  1      high from the cycle after accept until done
//   done         out  1      one-cycle pulse; result/flags valid from this cycle
//   result       out  WIDTH  final result; holds until next accepted start
//   zero         out  1      result == 0
//   cout         out  1      carry out of MSB (ADD/SUB only, else 0)
//   overflow     out  1      signed overflow (ADD/SUB only, else 0)
// BEHAVIOUR
//   - Reset: state=IDLE; busy, done, result, zero, cout and overflow are all 0; bit counter is 0.
//   - Slice decode per op as {A_invert,B_invert,op}:
//     AND {0,0,00}, OR {0,0,01}, ADD {0,0,10}, SUB/SLT {0,1,10}, NOR {1,1,00}.
//     Initial carry = B_invert.
//   - FSM IDLE -> RUN -> FINISH -> IDLE.
//   - IDLE: on start=1, latch src1, src2 and ALU_control; clear the result shift register.
//     Set carry = B_invert and counter = 0, then go to RUN.
//   - RUN: one bit per cycle; bit i = slice(src1[i], src2[i], carry); carry <= slice cout.
//     The less input is 0 during RUN. After bit WIDTH-1, go to FINISH.
//   - FINISH: compute the flags, commit result, pulse done for 1 cycle, return to IDLE.
//     Overflow = carry into MSB ^ carry out of MSB.
//     SLT: result = {WIDTH-1 zeros, sumMSB ^ overflow}; overflow and cout are forced to 0.
//     zero is evaluated on the committed result.
//   - Latency: start accepted at edge T gives done high after edge T+WIDTH+1, for every op.
//   - Throughput: one op per WIDTH+2 cycles; start may be held high for back-to-back ops.
//   - start while busy: ignored; the operand inputs are not re-sampled.
//   - Unsupported ALU_control: runs full latency, result=0, zero=1, cout=0, overflow=0.
//   - Reset mid-operation: abort immediately to IDLE with all outputs 0; done does not pulse.
//   - Operands and control are internal copies; src1/src2 may change freely after accept.
//   - Counter width $clog2(WIDTH); no wrap-around beyond WIDTH-1.
// CONFIGURATION
//   BSALU_EARLY_DONE_EN
//   - Defined: for AND, OR and NOR, the FSM skips FINISH.
//     The result is committed and done pulses in the last RUN cycle, giving latency WIDTH.
//   - ADD, SUB and SLT latency is unchanged.
//   - Undefined: uniform latency of WIDTH+1 for all ops.
// TESTING
//   1. ADD 0x7FFFFFFF+0x00000001: result 0x80000000, overflow 1, cout 0, zero 0.
//      done is high exactly 33 cycles after the accept edge.
//   2. SUB 0x00000005-0x00000005: result 0, zero 1, cout 1, overflow 0.
//   3. SLT with 0x80000000 vs 0x00000001: result 1.
//      SLT with 0x7FFFFFFF vs 0xFFFFFFFF: result 0.
//      Both cases have overflow 0.
//   4. NOR 0xF0F0F0F0,0x0F0F0F00: result 0x0000000F.
//      Latency is 32 cycles with BSALU_EARLY_DONE_EN, 33 without.
//   5. Assert rst 10 cycles into ADD: next cycle busy=0, result=0, no done pulse.
//      A new start then completes normally.
//   6. Pulse start again while busy with different operands: ignored.
//      The first op's result is unchanged and only one done pulse occurs.

Source files
------------

// File: rtl/bit_serial_alu_if.sv
// Start/busy/done bus between the CPU stall logic and the bit-serial ALU.
// A request is taken when start is high while the ALU is idle; busy then covers the run; done pulses once when results are valid.
interface bit_serial_alu_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [3:0]       ALU_control;
    logic [WIDTH-1:0] src1;
    logic [WIDTH-1:0] src2;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             cout;
    logic             overflow;
    logic [1:0]       dbg_state;

    modport master (
        output start, ALU_control, src1, src2,
        input  busy, done, result, zero, cout, overflow, dbg_state
    );

    modport slave (
        input  start, ALU_control, src1, src2,
        output busy, done, result, zero, cout, overflow, dbg_state
    );
endinterface

// File: rtl/bit_serial_alu.sv
// Multi-cycle ALU: one 1-bit ALU slice iterated LSB-first over WIDTH cycles.
// Define BSALU_EARLY_DONE_EN to let AND/OR/NOR finish in the last RUN cycle.
module bit_serial_alu #(
    parameter int WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    bit_serial_alu_if.slave         bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q, b_q, sr_q, result_q;
    logic             a_inv_q, b_inv_q;
    logic [1:0]       op_q;
    logic             valid_op_q, arith_q, slt_q;
    logic             carry_q, c_msb_in_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q, done_q, zero_q, cout_q, ovf_q;

    logic             dec_a_inv, dec_b_inv, dec_valid, dec_arith, dec_slt;
    logic [1:0]       dec_op;

    always_comb begin
        dec_a_inv = 1'b0;
        dec_b_inv = 1'b0;
        dec_op    = 2'b00;
        dec_valid = 1'b0;
        dec_arith = 1'b0;
        dec_slt   = 1'b0;
        case (bus.ALU_control)
            4'b0000: dec_valid = 1'b1;
            4'b0001: begin dec_op = 2'b01; dec_valid = 1'b1; end
            4'b0010: begin dec_op = 2'b10; dec_valid = 1'b1; dec_arith = 1'b1; end
            4'b0110: begin dec_op = 2'b10; dec_b_inv = 1'b1; dec_valid = 1'b1; dec_arith = 1'b1; end
            4'b0111: begin dec_op = 2'b10; dec_b_inv = 1'b1; dec_valid = 1'b1; dec_slt = 1'b1; end
            4'b1100: begin dec_a_inv = 1'b1; dec_b_inv = 1'b1; dec_valid = 1'b1; end
            default: ;
        endcase
    end

    // The single slice: less input is tied to 0 while bits are being produced.
    logic             sa_d, sb_d, bit_d, carry_d;
    logic [WIDTH-1:0] sr_d;

    always_comb begin
        sa_d = a_q[0] ^ a_inv_q;
        sb_d = b_q[0] ^ b_inv_q;
        case (op_q)
            2'b00:   bit_d = sa_d & sb_d;
            2'b01:   bit_d = sa_d | sb_d;
            2'b10:   bit_d = sa_d ^ sb_d ^ carry_q;
            default: bit_d = 1'b0;
        endcase
        carry_d = (sa_d & sb_d) | (sa_d & carry_q) | (sb_d & carry_q);
        sr_d    = {bit_d, sr_q[WIDTH-1:1]};
    end

    logic             fin_ovf_d;
    logic [WIDTH-1:0] fin_result_d;

    always_comb begin
        fin_ovf_d = c_msb_in_q ^ carry_q;
        if (!valid_op_q)
            fin_result_d = '0;
        else if (slt_q)
            fin_result_d = {{(WIDTH-1){1'b0}}, sr_q[WIDTH-1] ^ fin_ovf_d};
        else
            fin_result_d = sr_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            a_q        <= '0;
            b_q        <= '0;
            sr_q       <= '0;
            result_q   <= '0;
            a_inv_q    <= 1'b0;
            b_inv_q    <= 1'b0;
            op_q       <= 2'b00;
            valid_op_q <= 1'b0;
            arith_q    <= 1'b0;
            slt_q      <= 1'b0;
            carry_q    <= 1'b0;
            c_msb_in_q <= 1'b0;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            zero_q     <= 1'b0;
            cout_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        a_q        <= bus.src1;
                        b_q        <= bus.src2;
                        a_inv_q    <= dec_a_inv;
                        b_inv_q    <= dec_b_inv;
                        op_q       <= dec_op;
                        valid_op_q <= dec_valid;
                        arith_q    <= dec_arith;
                        slt_q      <= dec_slt;
                        sr_q       <= '0;
                        carry_q    <= dec_b_inv;
                        cnt_q      <= '0;
                        busy_q     <= 1'b1;
                        state_q    <= RUN;
                    end
                end
                RUN: begin
                    a_q     <= a_q >> 1;
                    b_q     <= b_q >> 1;
                    sr_q    <= sr_d;
                    carry_q <= carry_d;
                    if (cnt_q == LAST) begin
                        c_msb_in_q <= carry_q;
`ifdef BSALU_EARLY_DONE_EN
                        if (valid_op_q && !arith_q && !slt_q) begin
                            result_q <= sr_d;
                            zero_q   <= (sr_d == '0);
                            cout_q   <= 1'b0;
                            ovf_q    <= 1'b0;
                            done_q   <= 1'b1;
                            busy_q   <= 1'b0;
                            state_q  <= IDLE;
                        end else begin
                            state_q  <= FINISH;
                        end
`else
                        state_q <= FINISH;
`endif
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                FINISH: begin
                    result_q <= fin_result_d;
                    zero_q   <= (fin_result_d == '0);
                    cout_q   <= arith_q & carry_q;
                    ovf_q    <= arith_q & fin_ovf_d;
                    done_q   <= 1'b1;
                    busy_q   <= 1'b0;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.result    = result_q;
    assign bus.zero      = zero_q;
    assign bus.cout      = cout_q;
    assign bus.overflow  = ovf_q;
    assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_bit_serial_alu.sv
// Randomized self-checking bench for bit_serial_alu against an arithmetic reference model.
module tb_bit_serial_alu;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bit_serial_alu_if #(.WIDTH(W)) bus ();
    bit_serial_alu #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_checks = 0;
    int n_errors = 0;
    logic [W-1:0] exp_q[$];
    logic [3:0] ops [0:6] = '{4'h0, 4'h1, 4'h2, 4'h6, 4'hC, 4'h7, 4'h3};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] r, output logic co, output logic ov);
        logic [W:0] s;
        r = '0; co = 1'b0; ov = 1'b0;
        case (c)
            4'h0: r = a & b;
            4'h1: r = a | b;
            4'hC: r = ~(a | b);
            4'h2: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[W-1:0]; co = s[W];
                ov = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
            end
            4'h6: begin
                s = {1'b0, a} + {1'b0, ~b} + 1;
                r = s[W-1:0]; co = s[W];
                ov = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
            end
            4'h7: r = ($signed(a) < $signed(b)) ? 1 : 0;
            default: ;
        endcase
    endtask

    function automatic int exp_lat(input logic [3:0] c);
`ifdef BSALU_EARLY_DONE_EN
        if (c == 4'h0 || c == 4'h1 || c == 4'hC) return W;
`endif
        return W + 1;
    endfunction

    task automatic watch_no_done(input string tag, input int cycles);
        int extra = 0;
        repeat (cycles) begin
            @(posedge clk); #1;
            if (bus.done) extra++;
        end
        check(tag, extra, 0);
    endtask

    task automatic run_op(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b, input bit poke);
        logic [W-1:0] er, want;
        logic eco, eov;
        int n;
        bit seen;
        model(c, a, b, er, eco, eov);
        exp_q.push_back(er);
        @(negedge clk);
        bus.start = 1'b1; bus.ALU_control = c; bus.src1 = a; bus.src2 = b;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.src1 = $urandom; bus.src2 = $urandom; bus.ALU_control = 4'h2;
        check("busy_on_run", bus.busy, 1);
        n = 0; seen = 0;
        while (n < 100 && !seen) begin
            @(posedge clk); #1;
            n++;
            if (poke && n == 5) begin
                bus.start = 1'b1; bus.ALU_control = 4'h1; bus.src1 = ~a; bus.src2 = ~b;
            end
            if (poke && n == 6) bus.start = 1'b0;
            if (bus.done) seen = 1;
        end
        check("latency", n, exp_lat(c));
        want = exp_q.pop_front();
        check("result", bus.result, want);
        check("zero", bus.zero, (want == '0));
        check("cout", bus.cout, eco);
        check("overflow", bus.overflow, eov);
        check("busy_at_done", bus.busy, 0);
        @(posedge clk); #1;
        check("done_one_cycle", bus.done, 0);
        if (poke) watch_no_done("single_done", 40);
    endtask

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 4))
            0: return '0;
            1: return '1;
            2: return {1'b1, {(W-1){1'b0}}};
            3: return {1'b0, {(W-1){1'b1}}};
            default: return $urandom;
        endcase
    endfunction

    initial begin
        rst = 1'b1;
        bus.start = 1'b0; bus.ALU_control = 4'h0; bus.src1 = '0; bus.src2 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_result", bus.result, 0);
        check("rst_zero", bus.zero, 0);
        check("rst_cout", bus.cout, 0);
        check("rst_overflow", bus.overflow, 0);
        check("rst_state", bus.dbg_state, 0);
        @(negedge clk); rst = 1'b0;

        run_op(4'h2, 32'h7FFF_FFFF, 32'h0000_0001, 0);
        run_op(4'h6, 32'h0000_0005, 32'h0000_0005, 0);
        run_op(4'h7, 32'h8000_0000, 32'h0000_0001, 0);
        run_op(4'h7, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op(4'hC, 32'hF0F0_F0F0, 32'h0F0F_0F00, 0);
        run_op(4'h0, 32'hDEAD_BEEF, 32'h1234_5678, 1);

        // Abort an ADD part-way through with reset.
        run_op(4'h1, 32'h0000_00F0, 32'h0000_000F, 0);
        @(negedge clk);
        bus.start = 1'b1; bus.ALU_control = 4'h2; bus.src1 = 32'h1234_0000; bus.src2 = 32'h0000_4321;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        check("abort_busy", bus.busy, 0);
        check("abort_done", bus.done, 0);
        check("abort_result", bus.result, 0);
        check("abort_state", bus.dbg_state, 0);
        @(negedge clk); rst = 1'b0;
        watch_no_done("abort_no_done", 40);
        run_op(4'h2, 32'h0000_0003, 32'h0000_0004, 0);

        for (int i = 0; i < 30; i++)
            run_op(ops[$urandom_range(0, 6)], pick_operand(), pick_operand(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
